// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES helpers: GF(2^8) arithmetic, MixColumns
//                coefficients, column type and MixColumns FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    // Element 0 is the most significant byte, i.e. row 0 of the column.
    typedef logic [0:3][7:0] aes_col_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mc_state_t;

    // Row 0 coefficients; row r uses this vector rotated right by r.
    localparam logic [0:3][7:0] MC_FWD_COEF = {8'h02, 8'h03, 8'h01, 8'h01};
    localparam logic [0:3][7:0] MC_INV_COEF = {8'h0e, 8'h0b, 8'h0d, 8'h09};

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add over xtime powers; constant k lets synthesis prune unused terms.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [7:0] k);
        logic [7:0] acc;
        logic [7:0] pw;
        acc = '0;
        pw  = b;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) acc = acc ^ pw;
            pw = xtime(pw);
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mixcolumn_col.sv
`default_nettype none
// ============================================================================
//  Module      : mixcolumn_col
//  Description : Combinational forward/inverse MixColumns of one 32-bit column.
//  Revision    : 1.0 - initial release
// ============================================================================
module mixcolumn_col
    import aes_pkg::*;
#(
    parameter int INV_EN = 1
) (
    input  logic [31:0] col_i,
    input  logic        inv_i,
    output logic [31:0] col_o
);

    aes_col_t w_col;
    aes_col_t w_fwd;
    aes_col_t w_inv_res;
    logic     w_sel_inv;

    assign w_col = col_i;

    always_comb begin
        w_fwd = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                w_fwd[r] = w_fwd[r] ^ gf_mul(w_col[j], MC_FWD_COEF[2'(j - r)]);
            end
        end
    end

    generate
        if (INV_EN != 0) begin : g_inv
            always_comb begin
                w_inv_res = '0;
                for (int r = 0; r < 4; r++) begin
                    for (int j = 0; j < 4; j++) begin
                        w_inv_res[r] = w_inv_res[r] ^ gf_mul(w_col[j], MC_INV_COEF[2'(j - r)]);
                    end
                end
            end
            assign w_sel_inv = inv_i;
        end else begin : g_fwd_only
            logic w_unused_inv;
            assign w_unused_inv = inv_i;
            assign w_inv_res    = '0;
            assign w_sel_inv    = 1'b0;
        end
    endgenerate

    assign col_o = w_sel_inv ? w_inv_res : w_fwd;

endmodule
`default_nettype wire

// File: rtl/mixcolumn_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mixcolumn_seq
//  Description : Sequential MixColumns/InvMixColumns, COLS_PER_CYCLE columns
//                per clock, valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module mixcolumn_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter int INV_EN         = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] data_i,
    input  logic         inv_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] data_o,
    output logic         busy_o
);

    localparam int   N_STEPS   = 4 / COLS_PER_CYCLE;
    localparam int   CNT_W     = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam logic INV_BUILT = (INV_EN != 0);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
            $error("mixcolumn_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // Step s holds columns s*CPC .. s*CPC+CPC-1; step 0 sits at the MSB end.
    logic [0:N_STEPS-1][0:COLS_PER_CYCLE-1][31:0] r_work;
    mc_state_t                                    r_state;
    logic [CNT_W-1:0]                             r_cnt;
    logic                                         r_inv;

    logic [0:COLS_PER_CYCLE-1][31:0] w_slice;
    logic [0:COLS_PER_CYCLE-1][31:0] w_col_res;
    logic                            w_accept;

    assign w_slice = r_work[r_cnt];

    generate
        for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
            mixcolumn_col #(
                .INV_EN (INV_EN)
            ) u_col (
                .col_i (w_slice[k]),
                .inv_i (r_inv),
                .col_o (w_col_res[k])
            );
        end
    endgenerate

    // DONE can hand over its result and take the next state on the same edge.
    assign in_ready_o  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready_i);
    assign w_accept    = in_ready_o && in_valid_i;
    assign out_valid_o = (r_state == ST_DONE);
    assign busy_o      = (r_state == ST_RUN);
    assign data_o      = r_work;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
            r_inv   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_work  <= data_i;
                        r_inv   <= inv_i & INV_BUILT;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end else if (r_state == ST_DONE && out_ready_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_work[r_cnt] <= w_col_res;
                    if (r_cnt == CNT_W'(N_STEPS - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mixcolumn_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mixcolumn_seq
//  Description : Self-checking bench for mixcolumn_seq over CPC 1/2/4 and INV_EN 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mixcolumn_seq;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [3:0]          in_valid = '0;
    logic [3:0]          in_ready;
    logic [3:0]          inv = '0;
    logic [3:0]          out_valid;
    logic [3:0]          out_ready = '0;
    logic [3:0]          busy;
    logic [3:0][127:0]   din = '0;
    logic [3:0][127:0]   dout;

    int n_cmp = 0;
    int n_bad = 0;
    int nst [4] = '{4, 2, 1, 4};

    always #5 clk = ~clk;

    // Instance d: 0 = CPC1, 1 = CPC2, 2 = CPC4 (all with inverse), 3 = CPC1 forward only.
    mixcolumn_seq #(.COLS_PER_CYCLE(1), .INV_EN(1)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .data_i(din[0]), .inv_i(inv[0]), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
        .data_o(dout[0]), .busy_o(busy[0]));
    mixcolumn_seq #(.COLS_PER_CYCLE(2), .INV_EN(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .data_i(din[1]), .inv_i(inv[1]), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
        .data_o(dout[1]), .busy_o(busy[1]));
    mixcolumn_seq #(.COLS_PER_CYCLE(4), .INV_EN(1)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
        .data_i(din[2]), .inv_i(inv[2]), .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]),
        .data_o(dout[2]), .busy_o(busy[2]));
    mixcolumn_seq #(.COLS_PER_CYCLE(1), .INV_EN(0)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid[3]), .in_ready_o(in_ready[3]),
        .data_i(din[3]), .inv_i(inv[3]), .out_valid_o(out_valid[3]), .out_ready_i(out_ready[3]),
        .data_o(dout[3]), .busy_o(busy[3]));

    typedef struct {
        logic         inv;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t vt [6];

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s, input logic iv);
        logic [127:0] r = '0;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            if (!iv) begin
                r[127-32*c -: 8] = gm(a0,8'h02) ^ gm(a1,8'h03) ^ a2 ^ a3;
                r[119-32*c -: 8] = a0 ^ gm(a1,8'h02) ^ gm(a2,8'h03) ^ a3;
                r[111-32*c -: 8] = a0 ^ a1 ^ gm(a2,8'h02) ^ gm(a3,8'h03);
                r[103-32*c -: 8] = gm(a0,8'h03) ^ a1 ^ a2 ^ gm(a3,8'h02);
            end else begin
                r[127-32*c -: 8] = gm(a0,8'h0e) ^ gm(a1,8'h0b) ^ gm(a2,8'h0d) ^ gm(a3,8'h09);
                r[119-32*c -: 8] = gm(a0,8'h09) ^ gm(a1,8'h0e) ^ gm(a2,8'h0b) ^ gm(a3,8'h0d);
                r[111-32*c -: 8] = gm(a0,8'h0d) ^ gm(a1,8'h09) ^ gm(a2,8'h0e) ^ gm(a3,8'h0b);
                r[103-32*c -: 8] = gm(a0,8'h0b) ^ gm(a1,8'h0d) ^ gm(a2,8'h09) ^ gm(a3,8'h0e);
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int d, output int lat);
        lat = 0;
        while (!out_valid[d] && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume(input int d);
        out_ready[d] = 1'b1;
        tick();
        out_ready[d] = 1'b0;
    endtask

    // One full transaction: accept, scramble inputs, check latency and result, consume.
    task automatic xact(input int d, input logic iv, input logic [127:0] x,
                        input logic [127:0] exp, input string nm, output logic [127:0] y);
        int lat;
        chk({nm, "/in_ready"}, 128'(in_ready[d]), 128'd1);
        in_valid[d] = 1'b1;
        din[d]      = x;
        inv[d]      = iv;
        tick();
        in_valid[d] = 1'b0;
        din[d]      = {$urandom(), $urandom(), $urandom(), $urandom()};
        inv[d]      = ~iv;
        wait_done(d, lat);
        chk({nm, "/latency"}, 128'(lat), 128'(nst[d]));
        chk({nm, "/data"}, dout[d], exp);
        y = dout[d];
        consume(d);
        chk({nm, "/valid_drop"}, 128'(out_valid[d]), 128'd0);
    endtask

    initial begin
        logic [127:0] y, x, a_exp, b_exp;
        logic [127:0] st [8];
        logic         acc, ov, stale;
        logic [127:0] dv;
        int           lat, idx, got, cyc, last;

        vt[0] = '{1'b0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
        vt[1] = '{1'b1, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6};
        vt[2] = '{1'b0, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 128'h046681e5_e0cb199a_48f8d37a_2806264c};
        vt[3] = '{1'b1, 128'h046681e5_e0cb199a_48f8d37a_2806264c, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
        vt[4] = '{1'b0, 128'hd4d4d4d5_2d26314c_00000000_ffffffff, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff};
        vt[5] = '{1'b1, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, 128'hd4d4d4d5_2d26314c_00000000_ffffffff};

        // Reset
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst%0d/in_ready", d), 128'(in_ready[d]), 128'd1);
            chk($sformatf("rst%0d/out_valid", d), 128'(out_valid[d]), 128'd0);
            chk($sformatf("rst%0d/busy", d), 128'(busy[d]), 128'd0);
            chk($sformatf("rst%0d/data", d), dout[d], 128'd0);
        end

        // Table vectors on every instance that builds the inverse path
        for (int d = 0; d < 3; d++) begin
            for (int v = 0; v < 6; v++) begin
                xact(d, vt[v].inv, vt[v].din, vt[v].exp, $sformatf("vec d%0d v%0d", d, v), y);
            end
        end

        // Forward-only build ignores inv_i
        xact(3, 1'b0, vt[0].din, vt[0].exp, "fwdonly/fwd", y);
        xact(3, 1'b1, vt[1].din, mix(vt[1].din, 1'b0), "fwdonly/inv_ignored", y);

        // Random forward-then-inverse round trips
        for (int i = 0; i < 4; i++) begin
            x = {$urandom(), $urandom(), $urandom(), $urandom()};
            xact(0, 1'b0, x, mix(x, 1'b0), $sformatf("rt%0d/fwd", i), y);
            xact(0, 1'b1, y, x, $sformatf("rt%0d/inv", i), y);
        end

        // Backpressure in DONE with the next state already waiting
        a_exp = vt[0].exp;
        b_exp = vt[2].exp;
        in_valid[0] = 1'b1;
        din[0]      = vt[0].din;
        inv[0]      = 1'b0;
        tick();
        din[0] = vt[2].din;
        chk("bp/run_not_ready", 128'(in_ready[0]), 128'd0);
        wait_done(0, lat);
        chk("bp/latency", 128'(lat), 128'd4);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp/hold%0d", i), dout[0], a_exp);
            chk($sformatf("bp/not_ready%0d", i), 128'(in_ready[0]), 128'd0);
            tick();
        end
        chk("bp/still_valid", 128'(out_valid[0]), 128'd1);
        out_ready[0] = 1'b1;
        #1;
        chk("bp/ready_on_handshake", 128'(in_ready[0]), 128'd1);
        tick();
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b0;
        chk("bp/new_busy", 128'(busy[0]), 128'd1);
        chk("bp/new_valid", 128'(out_valid[0]), 128'd0);
        wait_done(0, lat);
        chk("bp/new_latency", 128'(lat), 128'd4);
        chk("bp/new_data", dout[0], b_exp);
        consume(0);

        // Back-to-back streaming on the two-column instance
        for (int i = 0; i < 8; i++) st[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        idx = 0; got = 0; cyc = 0; last = 0;
        in_valid[1]  = 1'b1;
        din[1]       = st[0];
        inv[1]       = 1'b0;
        out_ready[1] = 1'b1;
        while (got < 8 && cyc < 100) begin
            @(negedge clk);
            acc = in_valid[1] & in_ready[1];
            ov  = out_valid[1];
            dv  = dout[1];
            tick();
            cyc++;
            if (ov) begin
                chk($sformatf("b2b/data%0d", got), dv, mix(st[got], 1'b0));
                if (got > 0) chk($sformatf("b2b/interval%0d", got), 128'(cyc - last), 128'd3);
                last = cyc;
                got++;
            end
            if (acc) begin
                idx++;
                if (idx < 8) din[1] = st[idx];
                else in_valid[1] = 1'b0;
            end
        end
        chk("b2b/count", 128'(got), 128'd8);
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b0;

        // Reset on the second RUN cycle
        in_valid[0] = 1'b1;
        din[0]      = vt[2].din;
        inv[0]      = 1'b0;
        tick();
        in_valid[0] = 1'b0;
        tick();
        chk("rstrun/busy_before", 128'(busy[0]), 128'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rstrun/out_valid", 128'(out_valid[0]), 128'd0);
        chk("rstrun/busy", 128'(busy[0]), 128'd0);
        chk("rstrun/data", dout[0], 128'd0);
        chk("rstrun/in_ready", 128'(in_ready[0]), 128'd1);
        stale = 1'b0;
        repeat (10) begin
            tick();
            if (out_valid[0]) stale = 1'b1;
        end
        chk("rstrun/no_stale", 128'(stale), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
